// File: rtl/sm4_word_loader.sv
// -----------------------------------------------------------------------------
// sm4_word_loader
//
// Collects word_width_p-bit words from an upstream valid/ready stream and
// assembles them into one SM4 job for the downstream encryptor. A job is
// four key words followed by four content words. Each group is filled MSW
// first. The assembled job is offered downstream with a valid/ready handshake.
//
// Optional feature (macro SM4_LOADER_KEY_REUSE_EN):
//   The loader can reuse the previously loaded key. If skip_key_i is high on
//   the first word of a job and a complete key has already been loaded, that
//   word becomes content word 0 and only four words are needed. Without the
//   macro, skip_key_i is ignored and every job takes eight words.
//
// Ports:
//   clk_i              : clock
//   reset_i            : synchronous reset, active low (0 = reset)
//   word_i             : input data word
//   mode_i             : encode/decode flag, captured with a job's first word
//   skip_key_i         : key-reuse request, sampled with a job's first word
//   word_v_i           : input word valid
//   word_ready_o       : loader can accept a word
//   content_o          : assembled plaintext/ciphertext group
//   key_o              : assembled key group
//   encode_or_decode_o : captured mode of the job on offer
//   v_o                : assembled job valid toward the encryptor
//   ready_i            : encryptor can accept a job
// -----------------------------------------------------------------------------
module sm4_word_loader #(
    parameter int group_size_p = 128,
    parameter int word_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [word_width_p-1:0] word_i,
    input  logic                    mode_i,
    input  logic                    skip_key_i,
    input  logic                    word_v_i,
    output logic                    word_ready_o,
    output logic [group_size_p-1:0] content_o,
    output logic [group_size_p-1:0] key_o,
    output logic                    encode_or_decode_o,
    output logic                    v_o,
    input  logic                    ready_i
);

    typedef enum logic [1:0] {
        eKey     = 2'd0,
        eContent = 2'd1,
        eSend    = 2'd2
    } state_e;

    // Writes a word into slot k of a group. Slot 0 is the most significant
    // word.
    function automatic logic [group_size_p-1:0] place_word(
        input logic [group_size_p-1:0] group,
        input logic [1:0]              slot,
        input logic [word_width_p-1:0] word
    );
        logic [group_size_p-1:0] r;
        r = group;
        case (slot)
            2'd0:    r[32'sd3 * word_width_p +: word_width_p] = word;
            2'd1:    r[32'sd2 * word_width_p +: word_width_p] = word;
            2'd2:    r[32'sd1 * word_width_p +: word_width_p] = word;
            2'd3:    r[32'sd0 * word_width_p +: word_width_p] = word;
            default: r = group;
        endcase
        return r;
    endfunction

    state_e                  state_r, state_next_s;
    logic [1:0]              cnt_r, cnt_next_s;
    logic [group_size_p-1:0] key_r, key_next_s;
    logic [group_size_p-1:0] content_r, content_next_s;
    logic                    mode_r, mode_next_s;
    logic                    ready_s;
    logic                    accept_s;
    logic                    reuse_s;
    logic                    key_done_s;

`ifdef SM4_LOADER_KEY_REUSE_EN
    logic key_valid_r;

    // A key can be reused only after a complete key has been loaded.
    assign reuse_s = skip_key_i & key_valid_r;

    // Key-valid flag: set by the fourth key word and cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            key_valid_r <= 1'b0;
        end else if (key_done_s) begin
            key_valid_r <= 1'b1;
        end else begin
            key_valid_r <= key_valid_r;
        end
    end
`else
    logic unused_skip_key_s;

    assign reuse_s           = 1'b0;
    assign unused_skip_key_s = skip_key_i;
`endif

    // No word is accepted while a job is on offer or while reset is held.
    assign ready_s  = reset_i & (state_r != eSend);
    assign accept_s = word_v_i & ready_s;

    // Next-state, counter and data-capture logic.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        key_next_s     = key_r;
        content_next_s = content_r;
        mode_next_s    = mode_r;
        key_done_s     = 1'b0;
        case (state_r)
            eKey: begin
                if (accept_s) begin
                    // In eKey, a counter value of 0 always marks the first
                    // word of a job.
                    if (cnt_r == 2'd0) begin
                        mode_next_s = mode_i;
                    end else begin
                        mode_next_s = mode_r;
                    end
                    if ((cnt_r == 2'd0) && reuse_s) begin
                        // Keep the old key. This word is content word 0.
                        content_next_s = place_word(content_r, 2'd0, word_i);
                        cnt_next_s     = 2'd1;
                        state_next_s   = eContent;
                    end else begin
                        key_next_s = place_word(key_r, cnt_r, word_i);
                        if (cnt_r == 2'd3) begin
                            key_done_s   = 1'b1;
                            cnt_next_s   = 2'd0;
                            state_next_s = eContent;
                        end else begin
                            cnt_next_s = cnt_r + 2'd1;
                        end
                    end
                end else begin
                    state_next_s = eKey;
                end
            end
            eContent: begin
                if (accept_s) begin
                    content_next_s = place_word(content_r, cnt_r, word_i);
                    if (cnt_r == 2'd3) begin
                        cnt_next_s   = 2'd0;
                        state_next_s = eSend;
                    end else begin
                        cnt_next_s = cnt_r + 2'd1;
                    end
                end else begin
                    state_next_s = eContent;
                end
            end
            eSend: begin
                if (ready_i) begin
                    cnt_next_s   = 2'd0;
                    state_next_s = eKey;
                end else begin
                    state_next_s = eSend;
                end
            end
            default: begin
                cnt_next_s   = 2'd0;
                state_next_s = eKey;
            end
        endcase
    end

    // State, counter and assembled-job registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_r   <= eKey;
            cnt_r     <= 2'd0;
            key_r     <= {group_size_p{1'b0}};
            content_r <= {group_size_p{1'b0}};
            mode_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            key_r     <= key_next_s;
            content_r <= content_next_s;
            mode_r    <= mode_next_s;
        end
    end

    assign word_ready_o       = ready_s;
    assign v_o                = (state_r == eSend);
    assign key_o              = key_r;
    assign content_o          = content_r;
    assign encode_or_decode_o = mode_r;

endmodule

// File: tb/tb_sm4_word_loader.sv
// -----------------------------------------------------------------------------
// tb_sm4_word_loader
//
// Directed testbench for sm4_word_loader. When a job is driven, the bench
// pushes the expected key, content and mode into a queue. When the loader
// offers a job, the bench pops the expected values and compares them.
// -----------------------------------------------------------------------------
module tb_sm4_word_loader;

    typedef struct {
        logic [127:0] key;
        logic [127:0] content;
        logic         mode;
    } job_t;

    logic         clk_i;
    logic         reset_i;
    logic [31:0]  word_i;
    logic         mode_i;
    logic         skip_key_i;
    logic         word_v_i;
    logic         word_ready_o;
    logic [127:0] content_o;
    logic [127:0] key_o;
    logic         encode_or_decode_o;
    logic         v_o;
    logic         ready_i;

    job_t         exp_q[$];
    logic [127:0] last_key;
    int           pass_cnt;
    int           fail_cnt;
    int           total_cnt;

    sm4_word_loader #(
        .group_size_p(128),
        .word_width_p(32)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .word_i             (word_i),
        .mode_i             (mode_i),
        .skip_key_i         (skip_key_i),
        .word_v_i           (word_v_i),
        .word_ready_o       (word_ready_o),
        .content_o          (content_o),
        .key_o              (key_o),
        .encode_or_decode_o (encode_or_decode_o),
        .v_o                (v_o),
        .ready_i            (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stops a hung run with a failure report.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offers one word and waits, with a bound, until the loader accepts it.
    task automatic do_word(input logic [31:0] w, input logic m, input logic s, input bit gap);
        int n;
        if (gap) begin
            word_v_i = 1'b0;
            word_i   = 32'hBAD0_BAD0;
            tick();
        end
        word_i     = w;
        mode_i     = m;
        skip_key_i = s;
        word_v_i   = 1'b1;
        n = 0;
        while (word_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("word_accept_timeout", 128'd0, 128'd1);
        tick();
        word_v_i   = 1'b0;
        skip_key_i = 1'b0;
    endtask

    // Drives one job and pushes its expected result. Only the first word
    // carries the real mode and skip values. Later words carry the opposite
    // mode, which the loader must ignore.
    task automatic drive_job(input logic [127:0] key, input logic [127:0] content,
                             input logic mode, input logic skip, input bit send_key,
                             input bit gap);
        job_t e;
        int   nw;
        logic [255:0] stream;
        if (send_key) begin
            e.key  = key;
            stream = {key, content};
            nw     = 8;
        end else begin
            e.key  = last_key;
            stream = {content, 128'd0};
            nw     = 4;
        end
        e.content = content;
        e.mode    = mode;
        exp_q.push_back(e);
        last_key = e.key;
        for (int i = 0; i < nw; i++) begin
            if (i == nw - 1) check("v_o_before_last_word", {127'd0, v_o}, 128'd0);
            if (send_key && i == 4) check("v_o_after_four_words", {127'd0, v_o}, 128'd0);
            do_word(stream[255 - 32*i -: 32], (i == 0) ? mode : ~mode,
                    (i == 0) ? skip : 1'b0, gap);
        end
        // One cycle after the last word is accepted, the job is on offer.
        check("v_o_latency", {127'd0, v_o}, 128'd1);
        check("word_ready_in_send", {127'd0, word_ready_o}, 128'd0);
    endtask

    // Waits, with a bound, for a job on offer and compares it with the
    // oldest expected entry.
    task automatic check_job();
        job_t e;
        int   n;
        n = 0;
        while (v_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("v_o_wait", {127'd0, v_o}, 128'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 128'd1, 128'd0);
        end else begin
            e = exp_q.pop_front();
            check("key_o", key_o, e.key);
            check("content_o", content_o, e.content);
            check("encode_or_decode_o", {127'd0, encode_or_decode_o}, {127'd0, e.mode});
        end
    endtask

    localparam logic [127:0] pat_a = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] key_b = 128'hDEADBEEF_CAFEF00D_13572468_0F1E2D3C;
    localparam logic [127:0] cnt_b = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] key_c = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] cnt_c = 128'h00010002_00030004_00050006_00070008;
    localparam logic [127:0] pat_aa = {4{32'hAAAAAAAA}};

    initial begin
        pass_cnt   = 0;
        fail_cnt   = 0;
        total_cnt  = 0;
        last_key   = 128'd0;
        reset_i    = 1'b0;
        word_v_i   = 1'b0;
        word_i     = 32'd0;
        mode_i     = 1'b0;
        skip_key_i = 1'b0;
        ready_i    = 1'b1;

        // Reset state.
        repeat (3) tick();
        check("rst_word_ready", {127'd0, word_ready_o}, 128'd0);
        check("rst_v_o", {127'd0, v_o}, 128'd0);
        check("rst_key_o", key_o, 128'd0);
        check("rst_content_o", content_o, 128'd0);
        check("rst_mode", {127'd0, encode_or_decode_o}, 128'd0);
        reset_i = 1'b1;
        tick();
        check("post_rst_word_ready", {127'd0, word_ready_o}, 128'd1);

        // Single back-to-back job with mode 1 and ready_i held high.
        drive_job(pat_a, pat_a, 1'b1, 1'b0, 1'b1, 1'b0);
        check_job();
        tick();
        check("transfer_v_o_drop", {127'd0, v_o}, 128'd0);
        check("transfer_back_to_key", {127'd0, word_ready_o}, 128'd1);

        // Backpressure: the job and all outputs stay put, and offered words
        // are not consumed.
        ready_i = 1'b0;
        drive_job(key_b, cnt_b, 1'b0, 1'b0, 1'b1, 1'b0);
        check_job();
        for (int i = 0; i < 10; i++) begin
            word_v_i = 1'b1;
            word_i   = 32'h5555_5555;
            tick();
            check("bp_v_o", {127'd0, v_o}, 128'd1);
            check("bp_word_ready", {127'd0, word_ready_o}, 128'd0);
            check("bp_key_stable", key_o, key_b);
            check("bp_content_stable", content_o, cnt_b);
        end
        word_v_i = 1'b0;
        ready_i  = 1'b1;
        tick();
        check("bp_release_v_o", {127'd0, v_o}, 128'd0);
        check("bp_release_ready", {127'd0, word_ready_o}, 128'd1);

        // Gapped input: word_v_i toggles every cycle.
        drive_job(pat_a, pat_a, 1'b1, 1'b0, 1'b1, 1'b1);
        check_job();
        tick();

        // Reset mid-job after five words. The partial job is discarded.
        for (int i = 0; i < 5; i++) do_word(32'h0BAD0000 + i, 1'b1, 1'b0, 1'b0);
        reset_i = 1'b0;
        tick();
        check("midrst_v_o", {127'd0, v_o}, 128'd0);
        check("midrst_word_ready", {127'd0, word_ready_o}, 128'd0);
        check("midrst_key_o", key_o, 128'd0);
        check("midrst_content_o", content_o, 128'd0);
        reset_i = 1'b1;
        tick();
        // After reset no key is held, so the skip request is ignored and all
        // eight words are needed.
        drive_job(key_c, cnt_c, 1'b1, 1'b1, 1'b1, 1'b0);
        check_job();
        tick();

`ifdef SM4_LOADER_KEY_REUSE_EN
        // Key reuse: four content words only, with the previous key kept.
        drive_job(key_b, pat_aa, 1'b0, 1'b1, 1'b0, 1'b0);
        check_job();
        tick();
`else
        // Without key reuse, skip_key_i is ignored and eight words are needed.
        drive_job(key_b, pat_aa, 1'b0, 1'b1, 1'b1, 1'b0);
        check_job();
        tick();
`endif
        check("idle_v_o", {127'd0, v_o}, 128'd0);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sm4_word_loader.md
SM4_WORD_LOADER -- requirements
Module: sm4_word_loader

Interface
REQ-001 The block SHALL have parameter group_size_p, default 128, meaning the SM4 block, key and output group width in bits.
REQ-002 The block SHALL have parameter word_width_p, default 32, meaning the input word width in bits; group_size_p SHALL be exactly 4*word_width_p.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the only clock.
REQ-004 The block SHALL have port reset_i, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port word_i, input, word_width_p bits: the input data word.
REQ-006 The block SHALL have port mode_i, input, 1 bit: encode_or_decode value, sampled with the first word of a job.
REQ-007 The block SHALL have port skip_key_i, input, 1 bit: key-reuse request, sampled with the first word of a job.
REQ-008 The block SHALL have port word_v_i, input, 1 bit: input word valid.
REQ-009 The block SHALL have port word_ready_o, output, 1 bit: ready to accept a word.
REQ-010 The block SHALL have ports content_o and key_o, outputs, group_size_p bits each: the assembled plaintext/ciphertext and the assembled key.
REQ-011 The block SHALL have port encode_or_decode_o, output, 1 bit: the captured mode.
REQ-012 The block SHALL have port v_o, output, 1 bit: the assembled job is valid toward the downstream SM4 encryptor.
REQ-013 The block SHALL have port ready_i, input, 1 bit: the downstream encryptor can accept a job.

Function
REQ-014 A word SHALL transfer only in a cycle where word_v_i=1 and word_ready_o=1; a job transfers downstream only in a cycle where v_o=1 and ready_i=1.
REQ-015 The state machine SHALL have states eKey, eContent and eSend, and a 2-bit word counter.
REQ-016 In eKey, each accepted word SHALL fill key_o slice [127-32k:96-32k] for counter value k, MSW first; after the 4th key word the state SHALL go to eContent with the counter at 0.
REQ-017 In eContent, accepted words SHALL fill content_o in the same order; after the 4th content word the state SHALL go to eSend.
REQ-018 mode_i SHALL be captured only on the first accepted word of a job; later values SHALL be ignored.
REQ-019 word_ready_o SHALL be 1 in eKey and eContent, and 0 in eSend (including the downstream-transfer cycle) and while reset is asserted.
REQ-020 v_o SHALL be 1 exactly while in eSend; v_o rises the cycle after the final word is accepted (latency 1).
REQ-021 key_o, content_o and encode_or_decode_o SHALL hold stable while v_o=1.
REQ-022 On downstream transfer the state SHALL return to eKey with the counter at 0 on the next cycle; holding ready_i=0 SHALL hold eSend indefinitely.
REQ-023 A word offered while word_ready_o=0 SHALL NOT be consumed; the counter SHALL wrap from 3 to 0 only on a state change.

Reset
REQ-024 With reset_i=0 at a clock edge: state=eKey, counter=0, v_o=0, key_valid_r=0, encode_or_decode_o=0; key_o and content_o SHALL be reset to 0.
REQ-025 Reset asserted mid-job SHALL discard all partially collected words; the next job SHALL start with key word 0.

Configuration
REQ-026 Macro SM4_LOADER_KEY_REUSE_EN SHALL gate the key-reuse feature.
REQ-027 With the macro defined: key_valid_r SHALL set when a 4th key word is accepted; if skip_key_i=1 and key_valid_r=1 on a job's first word, that word SHALL be content word 0, the state SHALL be eContent with counter 1, and key_o SHALL retain the previous key.
REQ-028 With the macro defined and skip_key_i=1 while key_valid_r=0, skip_key_i SHALL be ignored.
REQ-029 Without the macro: skip_key_i SHALL be ignored, no key_valid_r logic SHALL be built, and every job SHALL take 8 words.

Verification
REQ-030 Single job: key words 0x01234567,0x89ABCDEF,0xFEDCBA98,0x76543210 then the same four as content, mode=1, ready_i=1 -> v_o=1 one cycle after word 8, key_o=content_o=0x0123456789ABCDEFFEDCBA9876543210, encode_or_decode_o=1.
REQ-031 Backpressure: ready_i=0 for 10 cycles after v_o rises -> v_o and outputs stable, word_ready_o=0, offered words not consumed; ready_i=1 -> eKey next cycle.
REQ-032 Gapped input: word_v_i toggled every cycle -> identical outputs to REQ-030, v_o after the 8th accepted word.
REQ-033 Reset mid-job: reset_i=0 after 5 words, then a full 8-word job -> output reflects only the new job; v_o=0 during reset.
REQ-034 Key reuse (macro defined): REQ-030 job, then a job of 4 words 0xAAAAAAAA with skip_key_i=1 -> key_o unchanged, content_o=0xAAAA...AAAA, v_o after the 4th word.
REQ-035 Key reuse (macro undefined, or key_valid_r=0 after reset): skip_key_i=1 -> the first word is taken as key word 0 and 8 words are required.
